ram_write_mc: RTL and testbench
===============================

# ram_write_mc

Multi-channel Avalon-MM waveform-RAM writer for the NIOS2 SOPC system. It takes CPU writes and drives the write ports of up to CH_N external dual-port sample/waveform RAMs: address, data and one-hot write-enable. It adds an auto-incrementing write pointer, per-channel or broadcast writes, and a hardware fill engine that writes one value over an address range without CPU involvement. It sits between the Avalon fabric and the DSO/DDS RAM blocks.

## Interface
- ADDR_W, 12, RAM address width
- DATA_W, 12, RAM data width (≤ 32)
- CH_N, 2, number of RAM channels (1..8)
- csi_clk  in  1  system clock; all logic is on its rising edge
- csi_reset  in  1  asynchronous, active-high reset
- avs_chipselect  in  1  slave select
- avs_address  in  3  register index
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data; registered, read latency 1
- avs_waitrequest  out  1  stall; combinational from busy and address
- coe_ram_addr  out  ADDR_W  RAM write address, registered
- coe_ram_data  out  DATA_W  RAM write data, registered
- coe_ram_we  out  CH_N  one-hot write enables (all ones in broadcast mode), registered single-cycle pulses

## Operation
Register map (word index):
- 0 DATA (W): writes writedata[DATA_W-1:0] at PTR. If AUTOINC=1, PTR increments afterwards.
- 1 PTR (R/W): write pointer, ADDR_W bits. Reset value 0.
- 2 CTRL (R/W)
  - bits[2:0] CH: channel select. Values ≥ CH_N are ignored on write.
  - bit 8 AUTOINC: reset value 1.
  - bit 9 BCAST: when set, all channels are written together.
  - bit 31 ABORT: write-only, self-clearing.
- 3 COUNT (R/W): fill length, ADDR_W+1 bits, so the full depth can be expressed. Reset value 0.
- 4 FILL (W): latches writedata[DATA_W-1:0] as the fill value and starts the fill engine.
- 5 STATUS (R)
  - bit0 BUSY.
  - bit1 DONE: sticky; cleared by a STATUS read or by a new FILL start.
  - bits[ADDR_W+15:16]: current PTR.
- Other indices: reads return 0, writes are ignored.

Write acceptance: a write is accepted when chipselect, write and !waitrequest are all high.

Fill FSM, states IDLE and FILL:
- IDLE→FILL on an accepted FILL write when COUNT ≠ 0. The remaining-words counter loads COUNT.
- A FILL write with COUNT = 0 causes no RAM writes, stays in IDLE, and sets DONE on the next cycle.
- In FILL: one RAM write per cycle at PTR. PTR increments every cycle regardless of AUTOINC. The counter decrements.
- FILL→IDLE after the last write (counter reaches 0). DONE is set in the same cycle.
- ABORT write during FILL: accepted. The state goes to IDLE at the next edge and no further writes are issued. DONE is not set. PTR holds the next unwritten address.

avs_waitrequest is 1 when BUSY and the access is a write to any address other than 2. Reads never stall.

Pointer arithmetic: PTR wraps modulo 2^ADDR_W, so ADDR_W'h…FFF + 1 = 0. A fill may wrap.

Reset:
- All outputs are 0: coe_ram_we = 0, addr = 0, data = 0, readdata = 0.
- FSM is IDLE. PTR = 0, COUNT = 0, CH = 0, AUTOINC = 1, BCAST = 0, DONE = 0.
- Reset asserted mid-fill stops it immediately and no write pulse is emitted.

## Timing
- DATA write accepted in cycle N:
  - coe_ram_we, addr (= old PTR) and data are valid for exactly cycle N+1.
  - PTR updates at the end of cycle N, so STATUS read in N+1 shows the new value.
- Back-to-back DATA writes sustain one RAM write per cycle.
- FILL accepted in cycle N:
  - BUSY = 1 from cycle N+1.
  - RAM writes occur in cycles N+1 … N+COUNT.
  - BUSY = 0 and DONE = 1 in cycle N+COUNT+1.
- PTR and CTRL writes take effect at the next edge. A DATA write in the following cycle uses the new values.
- Read issued in cycle N: avs_readdata is valid in cycle N+1.
- A STATUS read clears DONE at the edge ending cycle N. If a fill completes in the same cycle, the completion wins and DONE stays 1.

## Test plan
- Reset, then DATA writes 0x123, 0x456 with AUTOINC=1, CH=1 → coe_ram_we=2'b10 twice, addr 0 then 1, data 0x123 then 0x456; PTR reads 2.
- PTR=0xFFE, three DATA writes → addresses 0xFFE, 0xFFF, 0x000; PTR reads 1.
- BCAST=1, one DATA write 0xABC → coe_ram_we=2'b11 for one cycle.
- PTR=0x010, COUNT=5, FILL=0x7FF → writes at 0x010–0x014 on five consecutive cycles; a DATA write issued meanwhile has waitrequest high until BUSY drops; DONE=1, PTR=0x015.
- COUNT=4096, fill, ABORT after 10 writes → exactly 10 or 11 pulses as defined by acceptance cycle; BUSY=0, DONE=0; COUNT=0 FILL → no pulses, DONE=1.
- Assert csi_reset mid-fill → coe_ram_we drops asynchronously; all registers return to reset values.

Source files
------------

// File: rtl/ram_write_mc_if.sv
// Avalon-MM slave port plus external RAM write port of the waveform-RAM writer.
interface ram_write_mc_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12,
    parameter int CH_N   = 2
);
    logic              avs_chipselect;
    logic [2:0]        avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;
    logic [ADDR_W-1:0] coe_ram_addr;
    logic [DATA_W-1:0] coe_ram_data;
    logic [CH_N-1:0]   coe_ram_we;

    modport slave (
        input  avs_chipselect, avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata, avs_waitrequest,
        output coe_ram_addr, coe_ram_data, coe_ram_we
    );

    modport master (
        output avs_chipselect, avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata, avs_waitrequest,
        input  coe_ram_addr, coe_ram_data, coe_ram_we
    );
endinterface

// File: rtl/ram_write_mc.sv
// Multi-channel waveform-RAM writer: CPU data writes with auto-incrementing pointer,
// per-channel or broadcast enables, and a hardware fill engine.
//
// state  | meaning
// S_IDLE | CPU DATA writes accepted; FILL write starts the engine
// S_FILL | one RAM write per cycle at PTR until the remaining count hits 0
module ram_write_mc #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12,
    parameter int CH_N   = 2
) (
    input  logic          csi_clk,
    input  logic          csi_reset,
    ram_write_mc_if.slave bus
);
    typedef enum logic {S_IDLE, S_FILL} state_t;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_PTR    = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_COUNT  = 3'd3;
    localparam logic [2:0] A_FILL   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    localparam logic [3:0]        CH_N_L  = 4'(CH_N);
    localparam logic [CH_N-1:0]   WE_ONE  = CH_N'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   remain;
    logic [2:0]        ch;
    logic              autoinc;
    logic              bcast;
    logic              done;
    logic [DATA_W-1:0] fill_val;

    logic              busy;
    logic              wr_req;
    logic              wr_acc;
    logic              rd_acc;
    logic              ctrl_wr;
    logic              abort;
    logic [CH_N-1:0]   we_mask;
    logic [31:0]       rd_mux;
    logic              unused_wd;

    assign busy    = (state == S_FILL);
    assign wr_req  = bus.avs_chipselect & bus.avs_write;
    assign bus.avs_waitrequest = busy & wr_req & (bus.avs_address != A_CTRL);
    assign wr_acc  = wr_req & ~bus.avs_waitrequest;
    assign rd_acc  = bus.avs_chipselect & bus.avs_read;
    assign ctrl_wr = wr_acc & (bus.avs_address == A_CTRL);
    assign abort   = ctrl_wr & bus.avs_writedata[31];
    assign we_mask = bcast ? {CH_N{1'b1}} : (WE_ONE << ch);
    assign unused_wd = ^bus.avs_writedata;

    always_comb begin
        rd_mux = '0;
        case (bus.avs_address)
            A_PTR:   rd_mux[ADDR_W-1:0] = ptr;
            A_CTRL: begin
                rd_mux[2:0] = ch;
                rd_mux[8]   = autoinc;
                rd_mux[9]   = bcast;
            end
            A_COUNT: rd_mux[ADDR_W:0] = count;
            A_STATUS: begin
                rd_mux[0]             = busy;
                rd_mux[1]             = done;
                rd_mux[ADDR_W+15:16]  = ptr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            state            <= S_IDLE;
            ptr              <= '0;
            count            <= '0;
            remain           <= '0;
            ch               <= '0;
            autoinc          <= 1'b1;
            bcast            <= 1'b0;
            done             <= 1'b0;
            fill_val         <= '0;
            bus.avs_readdata <= '0;
            bus.coe_ram_addr <= '0;
            bus.coe_ram_data <= '0;
            bus.coe_ram_we   <= '0;
        end else begin
            bus.coe_ram_we <= '0;

            if (rd_acc) begin
                bus.avs_readdata <= rd_mux;
                if (bus.avs_address == A_STATUS) begin
                    done <= 1'b0;
                end
            end

            if (ctrl_wr) begin
                if ({1'b0, bus.avs_writedata[2:0]} < CH_N_L) begin
                    ch <= bus.avs_writedata[2:0];
                end
                autoinc <= bus.avs_writedata[8];
                bcast   <= bus.avs_writedata[9];
            end

            case (state)
                S_IDLE: begin
                    if (wr_acc) begin
                        case (bus.avs_address)
                            A_DATA: begin
                                bus.coe_ram_we   <= we_mask;
                                bus.coe_ram_addr <= ptr;
                                bus.coe_ram_data <= bus.avs_writedata[DATA_W-1:0];
                                if (autoinc) begin
                                    ptr <= ptr + PTR_ONE;
                                end
                            end
                            A_PTR:   ptr   <= bus.avs_writedata[ADDR_W-1:0];
                            A_COUNT: count <= bus.avs_writedata[ADDR_W:0];
                            A_FILL: begin
                                fill_val <= bus.avs_writedata[DATA_W-1:0];
                                if (count != '0) begin
                                    // first fill word goes out on the accepting edge
                                    state            <= S_FILL;
                                    bus.coe_ram_we   <= we_mask;
                                    bus.coe_ram_addr <= ptr;
                                    bus.coe_ram_data <= bus.avs_writedata[DATA_W-1:0];
                                    ptr              <= ptr + PTR_ONE;
                                    remain           <= count - CNT_ONE;
                                    done             <= 1'b0;
                                end else begin
                                    done <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_FILL: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (remain != '0) begin
                        bus.coe_ram_we   <= we_mask;
                        bus.coe_ram_addr <= ptr;
                        bus.coe_ram_data <= fill_val;
                        ptr              <= ptr + PTR_ONE;
                        remain           <= remain - CNT_ONE;
                    end else begin
                        // completion overrides a same-cycle STATUS read clear
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_write_mc.sv
// Directed self-checking bench for ram_write_mc: data writes, wrap, broadcast,
// fill with stall, abort, zero-length fill and reset mid-fill.
module tb_ram_write_mc;
    logic csi_clk;
    logic csi_reset;

    ram_write_mc_if #(.ADDR_W(12), .DATA_W(12), .CH_N(2)) bus ();

    ram_write_mc #(.ADDR_W(12), .DATA_W(12), .CH_N(2)) dut (
        .csi_clk   (csi_clk),
        .csi_reset (csi_reset),
        .bus       (bus)
    );

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_PTR    = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_COUNT  = 3'd3;
    localparam logic [2:0] A_FILL   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] q_we[$];
    int          q_cyc[$];

    initial csi_clk = 1'b0;
    always #5 csi_clk = ~csi_clk;

    always @(posedge csi_clk) cyc++;

    // pulse monitor, sampled mid-cycle
    always @(negedge csi_clk) begin
        if (!csi_reset && bus.coe_ram_we != '0) begin
            q_addr.push_back(32'(bus.coe_ram_addr));
            q_data.push_back(32'(bus.coe_ram_data));
            q_we.push_back(32'(bus.coe_ram_we));
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic clrq();
        q_addr = {};
        q_data = {};
        q_we   = {};
        q_cyc  = {};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge csi_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, output int stalls);
        int   n;
        logic st;
        n = 0;
        stalls = 0;
        bus.avs_chipselect = 1'b1;
        bus.avs_write      = 1'b1;
        bus.avs_address    = a;
        bus.avs_writedata  = d;
        do begin
            @(negedge csi_clk);
            st = bus.avs_waitrequest;
            @(posedge csi_clk);
            #1;
            if (st) stalls++;
            n++;
        end while (st && n < 50);
        bus.avs_chipselect = 1'b0;
        bus.avs_write      = 1'b0;
        if (n >= 50) chk("wr_accept_bound", 32'(st), 32'h0);
    endtask

    task automatic w(input logic [2:0] a, input logic [31:0] d);
        int s;
        wr(a, d, s);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] q);
        bus.avs_chipselect = 1'b1;
        bus.avs_read       = 1'b1;
        bus.avs_address    = a;
        @(posedge csi_clk);
        #1;
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        q = bus.avs_readdata;
    endtask

    initial begin
        logic [31:0] r;
        int          st;

        csi_reset          = 1'b1;
        bus.avs_chipselect = 1'b0;
        bus.avs_address    = 3'd0;
        bus.avs_write      = 1'b0;
        bus.avs_writedata  = 32'h0;
        bus.avs_read       = 1'b0;
        repeat (3) @(posedge csi_clk);
        #1;
        csi_reset = 1'b0;

        // reset state
        chk("rst_we",    32'(bus.coe_ram_we), 32'h0);
        chk("rst_addr",  32'(bus.coe_ram_addr), 32'h0);
        chk("rst_data",  32'(bus.coe_ram_data), 32'h0);
        chk("rst_rdata", bus.avs_readdata, 32'h0);
        rd(A_CTRL, r);   chk("rst_ctrl", r, 32'h0000_0100);
        rd(A_STATUS, r); chk("rst_status", r, 32'h0);
        rd(A_COUNT, r);  chk("rst_count", r, 32'h0);

        // channel 1 data writes, back to back
        w(A_CTRL, 32'h0000_0101);
        clrq();
        wr(A_DATA, 32'h0000_0123, st);
        chk("d1_we",   32'(bus.coe_ram_we), 32'h2);
        chk("d1_addr", 32'(bus.coe_ram_addr), 32'h000);
        chk("d1_data", 32'(bus.coe_ram_data), 32'h123);
        wr(A_DATA, 32'h0000_0456, st);
        chk("d2_we",   32'(bus.coe_ram_we), 32'h2);
        chk("d2_addr", 32'(bus.coe_ram_addr), 32'h001);
        chk("d2_data", 32'(bus.coe_ram_data), 32'h456);
        rd(A_STATUS, r);
        chk("d_status_ptr", r, 32'h0002_0000);
        chk("d_we_single", 32'(bus.coe_ram_we), 32'h0);
        chk("d_npulse", 32'(q_addr.size()), 32'd2);
        chk("d_b2b", 32'(q_cyc[1] - q_cyc[0]), 32'd1);

        // pointer wrap
        w(A_PTR, 32'h0000_0FFE);
        clrq();
        w(A_DATA, 32'h1);
        w(A_DATA, 32'h2);
        w(A_DATA, 32'h3);
        idle(2);
        chk("wrap_npulse", 32'(q_addr.size()), 32'd3);
        chk("wrap_a0", q_addr[0], 32'hFFE);
        chk("wrap_a1", q_addr[1], 32'hFFF);
        chk("wrap_a2", q_addr[2], 32'h000);
        rd(A_PTR, r); chk("wrap_ptr", r, 32'h1);

        // broadcast
        w(A_CTRL, 32'h0000_0301);
        clrq();
        w(A_DATA, 32'h0000_0ABC);
        idle(2);
        chk("bc_npulse", 32'(q_addr.size()), 32'd1);
        chk("bc_we",   q_we[0], 32'h3);
        chk("bc_data", q_data[0], 32'hABC);
        chk("bc_addr", q_addr[0], 32'h001);

        // out-of-range channel ignored, autoinc off
        w(A_CTRL, 32'h0000_0005);
        rd(A_CTRL, r); chk("ch_ignore", r, 32'h0000_0001);
        wr(A_DATA, 32'h0000_0055, st);
        chk("noinc_we",   32'(bus.coe_ram_we), 32'h2);
        chk("noinc_addr", 32'(bus.coe_ram_addr), 32'h002);
        rd(A_PTR, r); chk("noinc_ptr", r, 32'h2);

        // fill of five words with a stalled DATA write behind it
        w(A_CTRL, 32'h0000_0100);
        w(A_PTR, 32'h0000_0010);
        w(A_COUNT, 32'd5);
        clrq();
        wr(A_FILL, 32'h0000_07FF, st);
        chk("f_first_we",   32'(bus.coe_ram_we), 32'h1);
        chk("f_first_addr", 32'(bus.coe_ram_addr), 32'h010);
        chk("f_first_data", 32'(bus.coe_ram_data), 32'h7FF);
        wr(A_DATA, 32'h0000_0111, st);
        chk("f_stalls", 32'(st), 32'd5);
        chk("f_dw_addr", 32'(bus.coe_ram_addr), 32'h015);
        chk("f_dw_data", 32'(bus.coe_ram_data), 32'h111);
        idle(1);
        chk("f_npulse", 32'(q_addr.size()), 32'd6);
        for (int i = 0; i < 5; i++) begin
            chk("f_addr", q_addr[i], 32'h10 + 32'(i));
            chk("f_data", q_data[i], 32'h7FF);
        end
        chk("f_span", 32'(q_cyc[4] - q_cyc[0]), 32'd4);
        rd(A_COUNT, r);  chk("f_count_kept", r, 32'd5);
        rd(A_STATUS, r); chk("f_status_done", r, 32'h0016_0002);
        rd(A_STATUS, r); chk("f_status_clr", r, 32'h0016_0000);

        // full-depth fill aborted after ten writes
        w(A_COUNT, 32'h0000_1000);
        w(A_PTR, 32'h0);
        clrq();
        w(A_FILL, 32'h0000_05A5);
        idle(9);
        wr(A_CTRL, 32'h8000_0100, st);
        chk("ab_nostall", 32'(st), 32'd0);
        idle(3);
        chk("ab_npulse", 32'(q_addr.size()), 32'd10);
        chk("ab_last_addr", q_addr[9], 32'h009);
        rd(A_STATUS, r); chk("ab_status", r, 32'h000A_0000);
        rd(A_CTRL, r);   chk("ab_ctrl", r, 32'h0000_0100);
        rd(A_COUNT, r);  chk("ab_count", r, 32'h0000_1000);

        // zero-length fill
        w(A_COUNT, 32'd0);
        clrq();
        w(A_FILL, 32'h0000_0123);
        rd(A_STATUS, r); chk("z_status", r, 32'h000A_0002);
        idle(2);
        chk("z_npulse", 32'(q_addr.size()), 32'd0);

        // reset in the middle of a fill
        w(A_COUNT, 32'd8);
        w(A_PTR, 32'h0000_0100);
        w(A_FILL, 32'h0000_03C3);
        idle(2);
        chk("r_we_before", 32'(bus.coe_ram_we), 32'h1);
        #2;
        csi_reset = 1'b1;
        #1;
        chk("r_we_async",   32'(bus.coe_ram_we), 32'h0);
        chk("r_addr_async", 32'(bus.coe_ram_addr), 32'h0);
        idle(2);
        csi_reset = 1'b0;
        clrq();
        rd(A_PTR, r);    chk("r_ptr", r, 32'h0);
        rd(A_CTRL, r);   chk("r_ctrl", r, 32'h0000_0100);
        rd(A_COUNT, r);  chk("r_count", r, 32'h0);
        rd(A_STATUS, r); chk("r_status", r, 32'h0);
        idle(2);
        chk("r_npulse", 32'(q_addr.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
